// File: rtl/gpr_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpr_wb_ctrl_if
// Bundle of everything that flows between the write-back controller and its
// neighbours: the ALU result path, the mul/div valid/ready path, the
// register-file write port and the status outputs seen by decode.
//
//   alu_valid/alu_rd/alu_data/alu_ovf   ALU result, always accepted
//   md_valid/md_ready/md_rd/md_data     mul/div result handshake
//   rw/busW/Reg_Wr/Reg_Dst              register-file write port
//   pend_mask                           per-register queued mul/div writes
//   hold_alu                            one-cycle ALU freeze request
//   proto_err                           sticky: ALU result offered during hold
//
// The slave modport is the controller's view; the master modport is the view
// of whatever drives the result paths and consumes the write port.
// ---------------------------------------------------------------------------
interface gpr_wb_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ovf;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic [4:0]  rw;
    logic [31:0] busW;
    logic        Reg_Wr;
    logic [1:0]  Reg_Dst;
    logic [31:0] pend_mask;
    logic        hold_alu;
    logic        proto_err;

    modport slave (
        input  alu_valid, alu_rd, alu_data, alu_ovf,
        input  md_valid, md_rd, md_data,
        output md_ready,
        output rw, busW, Reg_Wr, Reg_Dst,
        output pend_mask, hold_alu, proto_err
    );

    modport master (
        output alu_valid, alu_rd, alu_data, alu_ovf,
        output md_valid, md_rd, md_data,
        input  md_ready,
        input  rw, busW, Reg_Wr, Reg_Dst,
        input  pend_mask, hold_alu, proto_err
    );
endinterface

// File: rtl/gpr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// gpr_wb_ctrl
// Write-back controller for the 32x32 register file. Merges the single-cycle
// ALU result and the buffered multi-cycle mul/div result into one registered
// write port, tracks which registers still have a queued mul/div write, and
// forces the ALU to yield when the mul/div queue has been starved too long.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   wb    ifc  gpr_wb_ctrl_if.slave (result paths, write port, status)
//
// Parameters:
//   DEPTH       mul/div FIFO entries (power of 2, >= 2)
//   STARVE_LIM  lost cycles tolerated before hold_alu is raised
// ---------------------------------------------------------------------------
module gpr_wb_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic         clk,
    input  logic         rst,
    gpr_wb_ctrl_if.slave wb
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_OVF,
        SRC_FIFO
    } src_t;

    logic [4:0]    r_fifoRd   [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    logic [31:0]   r_pendMask;
    logic [CW-1:0] r_starveCnt;
    logic          r_holdAlu;
    logic          r_protoErr;
    logic [4:0]    r_rw;
    logic [31:0]   r_busW;
    logic          r_regWr;
    logic [1:0]    r_regDst;

    logic          w_empty;
    logic          w_full;
    logic          w_mdReady;
    logic          w_push;
    logic          w_pop;
    src_t          w_src;
    logic [CW-1:0] w_starveNext;
    logic [31:0]   w_pushMask;
    logic [31:0]   w_popMask;
    logic [4:0]    w_headRd;
    logic [31:0]   w_headData;

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    // A duplicate destination is refused so writes to one register stay in
    // order; a pop in the same cycle never frees a slot for the push.
    // rd=0 completes the handshake but is never stored.
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                        (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_mdReady  = ~rst & ~w_full & ~r_pendMask[wb.md_rd];
    assign w_push     = wb.md_valid & w_mdReady & (wb.md_rd != 5'd0);
    assign w_headRd   = r_fifoRd[r_rdPtr[AW-1:0]];
    assign w_headData = r_fifoData[r_rdPtr[AW-1:0]];

    // Pick this cycle's write source. A forced hold gives the FIFO head the
    // port no matter what the ALU does. An ALU write to r0 without overflow
    // still owns the cycle, so the FIFO waits even though nothing is written.
    always_comb begin
        w_src = SRC_NONE;
        if (r_holdAlu) begin
            if (!w_empty) begin
                w_src = SRC_FIFO;
            end
        end else if (wb.alu_valid) begin
            if (wb.alu_ovf) begin
                w_src = SRC_OVF;
            end else if (wb.alu_rd != 5'd0) begin
                w_src = SRC_ALU;
            end
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
        end
    end

    assign w_pop      = (w_src == SRC_FIFO);
    assign w_pushMask = w_push ? (32'd1 << wb.md_rd) : 32'd0;
    assign w_popMask  = w_pop  ? (32'd1 << w_headRd) : 32'd0;

    // Count consecutive cycles in which a waiting FIFO head is passed over.
    // The count saturates at the limit and clears on any pop or when empty.
    always_comb begin
        w_starveNext = r_starveCnt;
        if (w_empty || w_pop) begin
            w_starveNext = '0;
        end else if (r_starveCnt != LIM) begin
            w_starveNext = r_starveCnt + CW'(1);
        end
    end

    // FIFO payload storage needs no reset; only the pointers give it meaning.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoRd[r_wrPtr[AW-1:0]]   <= wb.md_rd;
            r_fifoData[r_wrPtr[AW-1:0]] <= wb.md_data;
        end
    end

    // Queue bookkeeping. hold_alu is raised on the edge where the counter
    // reaches the limit; the forced pop that follows clears the counter, so
    // hold_alu lasts exactly one cycle. proto_err latches any ALU result
    // offered while the ALU was told to hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_pendMask  <= '0;
            r_starveCnt <= '0;
            r_holdAlu   <= 1'b0;
            r_protoErr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
            r_pendMask  <= (r_pendMask & ~w_popMask) | w_pushMask;
            r_starveCnt <= w_starveNext;
            r_holdAlu   <= (w_starveNext == LIM);
            if (r_holdAlu && wb.alu_valid) begin
                r_protoErr <= 1'b1;
            end
        end
    end

    // Registered write port. Address, data and destination type keep their
    // last value on idle cycles; only the enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw     <= '0;
            r_busW   <= '0;
            r_regWr  <= 1'b0;
            r_regDst <= 2'b00;
        end else begin
            r_regWr <= (w_src != SRC_NONE);
            case (w_src)
                SRC_ALU: begin
                    r_rw     <= wb.alu_rd;
                    r_busW   <= wb.alu_data;
                    r_regDst <= 2'b00;
                end
                SRC_OVF: begin
                    r_rw     <= 5'd0;
                    r_busW   <= 32'd0;
                    r_regDst <= 2'b11;
                end
                SRC_FIFO: begin
                    r_rw     <= w_headRd;
                    r_busW   <= w_headData;
                    r_regDst <= 2'b00;
                end
                default: begin
                end
            endcase
        end
    end

    assign wb.md_ready  = w_mdReady;
    assign wb.rw        = r_rw;
    assign wb.busW      = r_busW;
    assign wb.Reg_Wr    = r_regWr;
    assign wb.Reg_Dst   = r_regDst;
    assign wb.pend_mask = r_pendMask;
    assign wb.hold_alu  = r_holdAlu;
    assign wb.proto_err = r_protoErr;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpr_wb_ctrl
// Directed bench for gpr_wb_ctrl (DEPTH=4, STARVE_LIM=8). Stimulus pushes the
// hand-computed register-file writes into a queue in port order; a monitor
// on the falling edge pops and compares each write the DUT presents, and
// flags any write nobody expected. Status outputs are compared directly.
// ---------------------------------------------------------------------------
module tb_gpr_wb_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gpr_wb_ctrl_if bus ();

    gpr_wb_ctrl #(
        .DEPTH      (4),
        .STARVE_LIM (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  dst;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    // Scoreboard monitor: every write on the port must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.Reg_Wr === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got rw=%0d busW=%h Reg_Dst=%b, required no write",
                         bus.rw, bus.busW, bus.Reg_Dst);
            end else begin
                e = expQ.pop_front();
                if (bus.rw !== e.rd || bus.busW !== e.data || bus.Reg_Dst !== e.dst) begin
                    errors++;
                    $display("[TB] FAIL write_port: got rw=%0d busW=%h Reg_Dst=%b, required rw=%0d busW=%h Reg_Dst=%b",
                             bus.rw, bus.busW, bus.Reg_Dst, e.rd, e.data, e.dst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic aovf, input logic mv, input logic [4:0] mrd,
                                 input logic [31:0] mdata);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.alu_ovf   = aovf;
        bus.md_valid  = mv;
        bus.md_rd     = mrd;
        bus.md_data   = mdata;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data, input logic [1:0] dst);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        e.dst  = dst;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_Reg_Wr"},    32'(bus.Reg_Wr),    32'd0);
        checkOutput({tag, "_rw"},        32'(bus.rw),        32'd0);
        checkOutput({tag, "_busW"},      bus.busW,           32'd0);
        checkOutput({tag, "_Reg_Dst"},   32'(bus.Reg_Dst),   32'd0);
        checkOutput({tag, "_pend_mask"}, bus.pend_mask,      32'd0);
        checkOutput({tag, "_md_ready"},  32'(bus.md_ready),  32'd0);
        checkOutput({tag, "_hold_alu"},  32'(bus.hold_alu),  32'd0);
        checkOutput({tag, "_proto_err"}, 32'(bus.proto_err), 32'd0);
    endtask

    initial begin
        // Power-on reset.
        idle();
        rst = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Plain ALU write, then the port holds address/data when idle.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        expectWrite(5'd5, 32'hDEADBEEF, 2'b00);
        tick();
        idle();
        tick();
        checkOutput("idle_Reg_Wr", 32'(bus.Reg_Wr), 32'd0);
        checkOutput("hold_rw",     32'(bus.rw),     32'd5);
        checkOutput("hold_busW",   bus.busW,        32'hDEADBEEF);

        // Overflow flag write; the destination type holds afterwards.
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 5'd0, 32'd0);
        expectWrite(5'd0, 32'd0, 2'b11);
        tick();
        idle();
        tick();
        checkOutput("hold_Reg_Dst", 32'(bus.Reg_Dst), 32'd3);

        // ALU write to r0 without overflow issues nothing.
        applyStimulus(1'b1, 5'd0, 32'h0000CAFE, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        tick();
        checkOutput("r0_Reg_Wr", 32'(bus.Reg_Wr), 32'd0);

        // Fill the FIFO with rd 1..4 while the ALU owns the port.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 32'(32'hA0 + i), 1'b0, 1'b1, 5'(1 + i), 32'(32'h100 + i));
            checkOutput("md_ready_fill", 32'(bus.md_ready), 32'd1);
            expectWrite(5'(20 + i), 32'(32'hA0 + i), 2'b00);
            tick();
        end
        applyStimulus(1'b1, 5'd24, 32'hA4, 1'b0, 1'b1, 5'd5, 32'h105);
        checkOutput("md_ready_full",  32'(bus.md_ready), 32'd0);
        checkOutput("pend_mask_full", bus.pend_mask,     32'h0000001E);
        expectWrite(5'd24, 32'hA4, 2'b00);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            expectWrite(5'(1 + i), 32'(32'h100 + i), 2'b00);
        end
        repeat (5) tick();
        checkOutput("pend_mask_drained", bus.pend_mask, 32'd0);

        // Collision: ALU rd 7 beats FIFO head rd 9.
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 5'd9, 32'h99);
        expectWrite(5'd8, 32'h88, 2'b00);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("pend_mask_r9", bus.pend_mask, 32'h00000200);
        expectWrite(5'd7, 32'h77, 2'b00);
        expectWrite(5'd9, 32'h99, 2'b00);
        tick();
        idle();
        tick();
        tick();
        checkOutput("pend_mask_collision", bus.pend_mask, 32'd0);

        // Duplicate destination stalls until the first rd 6 pops.
        applyStimulus(1'b1, 5'd10, 32'h1010, 1'b0, 1'b1, 5'd6, 32'h600);
        checkOutput("md_ready_first6", 32'(bus.md_ready), 32'd1);
        expectWrite(5'd10, 32'h1010, 2'b00);
        tick();
        applyStimulus(1'b1, 5'd11, 32'h1111, 1'b0, 1'b1, 5'd6, 32'h601);
        checkOutput("md_ready_dup",  32'(bus.md_ready), 32'd0);
        checkOutput("pend_mask_dup", bus.pend_mask,     32'h00000040);
        expectWrite(5'd11, 32'h1111, 2'b00);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd6, 32'h601);
        checkOutput("md_ready_dup_pop", 32'(bus.md_ready), 32'd0);
        expectWrite(5'd6, 32'h600, 2'b00);
        tick();
        checkOutput("md_ready_after_pop", 32'(bus.md_ready), 32'd1);
        expectWrite(5'd6, 32'h601, 2'b00);
        tick();
        idle();
        repeat (3) tick();
        checkOutput("pend_mask_dup_done", bus.pend_mask, 32'd0);

        // Starvation: rd 3 waits behind a busy ALU until hold_alu forces it.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5'(12 + i), 32'(32'hA00 + i), 1'b0, (i == 0), 5'd3, 32'h333);
            checkOutput("hold_alu_starve",  32'(bus.hold_alu),  32'(i == 9));
            checkOutput("proto_err_before", 32'(bus.proto_err), 32'd0);
            if (i < 9) expectWrite(5'(12 + i), 32'(32'hA00 + i), 2'b00);
            else       expectWrite(5'd3, 32'h333, 2'b00);
            tick();
        end
        idle();
        checkOutput("hold_alu_one_cycle", 32'(bus.hold_alu),  32'd0);
        checkOutput("proto_err_set",      32'(bus.proto_err), 32'd1);
        tick();
        tick();
        checkOutput("proto_err_sticky",   32'(bus.proto_err), 32'd1);
        checkOutput("pend_mask_starve",   bus.pend_mask,      32'd0);

        // Reset with three entries queued discards them.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(24 + i), 32'(32'hB0 + i), 1'b0, 1'b1, 5'(1 + i), 32'(32'h200 + i));
            expectWrite(5'(24 + i), 32'(32'hB0 + i), 2'b00);
            tick();
        end
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("pend_mask_queued", bus.pend_mask, 32'h0000000E);
        tick();
        idle();
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        tick();
        rst = 1'b0;
        repeat (6) tick();
        checkOutput("post_reset_pend_mask", bus.pend_mask,      32'd0);
        checkOutput("post_reset_md_ready",  32'(bus.md_ready),  32'd1);
        checkOutput("post_reset_proto_err", 32'(bus.proto_err), 32'd0);

        // Every expected write must have been seen.
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
